// File: rtl/mode_switch_sequencer.sv
// mode_switch_sequencer: safe video-mode change between the config decoder and the pixel PLL / timing generator.
// Ports:
//   i_clock, i_reset_n          clock, asynchronous active-low reset
//   i_config_data[7:0]          decoded mode code (opaque)
//   i_config_changed            one-cycle pulse when the mode code changed
//   o_pll_reconf_req            PLL reprogram request (level)
//   o_pll_reconf_mode[7:0]      mode to program, stable while the request is high
//   i_pll_reconf_ack            PLL reprogram done
//   i_pll_locked                PLL lock, already synchronised
//   o_video_reset               holds the timing generator in reset
//   o_output_enable             video output enable
//   o_active_mode[7:0]          mode currently programmed
//   o_busy                      high in every state except RUN
//   o_error                     sticky lock-timeout flag
// Optional: define MODE_SWITCH_LOCK_TIMEOUT_EN to bound WAIT_LOCK by LOCK_TIMEOUT cycles.
`ifndef MODE_VGA
`define MODE_VGA 8'h01
`endif
`ifndef MODE_720p
`define MODE_720p 8'h02
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h03
`endif
module mode_switch_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLANK_CYCLES    = 1024,
  parameter int SETTLE_CYCLES   = 65536,
  parameter int LOCK_TIMEOUT    = 4000000
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [7:0] i_config_data,
  input  logic       i_config_changed,
  output logic       o_pll_reconf_req,
  output logic [7:0] o_pll_reconf_mode,
  input  logic       i_pll_reconf_ack,
  input  logic       i_pll_locked,
  output logic       o_video_reset,
  output logic       o_output_enable,
  output logic [7:0] o_active_mode,
  output logic       o_busy,
  output logic       o_error
);
  localparam logic [2:0] S_DEBOUNCE  = 3'd0;
  localparam logic [2:0] S_RECONF    = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_BLANK     = 3'd4;
  localparam int MAX_DB  = (DEBOUNCE_CYCLES > BLANK_CYCLES) ? DEBOUNCE_CYCLES : BLANK_CYCLES;
  localparam int MAX_DBS = (MAX_DB > SETTLE_CYCLES) ? MAX_DB : SETTLE_CYCLES;
  localparam int MAX_ALL = (MAX_DBS > LOCK_TIMEOUT) ? MAX_DBS : LOCK_TIMEOUT;
  localparam int CW = $clog2(MAX_ALL + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYCLES - 1);
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_cand;
  logic [7:0]    r_active;
  logic [7:0]    r_mode;
  logic          r_init;
  logic          r_primed;
  logic          r_req;
  logic          r_vreset;
  logic          r_oe;
  logic [CW-1:0] w_cnt_inc;
  logic          w_cand_eq;
  logic          w_settled;
  logic          w_timeout;
  // One counter serves debounce, settle and blank; it is cleared on every state change.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
  // Until the first clock the candidate is taken to be whatever config_data shows.
  assign w_cand_eq = !r_primed || (i_config_data == r_cand);
  assign w_settled = i_pll_locked && (r_cnt == ST_LAST);
`ifdef MODE_SWITCH_LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
  logic [CW-1:0] r_tcnt;
  logic          r_error;
  assign w_timeout = (r_state == S_WAIT_LOCK) && !w_settled && (r_tcnt == LT_LAST);
  // Held at zero outside WAIT_LOCK, so every entry starts a fresh timeout window.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tcnt  <= '0;
      r_error <= 1'b0;
    end else begin
      r_tcnt <= (r_state == S_WAIT_LOCK) ? ((&r_tcnt) ? r_tcnt : r_tcnt + CW'(1)) : '0;
      if (w_timeout) r_error <= 1'b1;
    end
  end
  assign o_error = r_error;
`else
  assign w_timeout = 1'b0;
  assign o_error   = 1'b0;
`endif
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_DEBOUNCE;
      r_cnt    <= '0;
      r_cand   <= `MODE_VGA;
      r_active <= `MODE_VGA;
      r_mode   <= `MODE_VGA;
      r_init   <= 1'b1;
      r_primed <= 1'b0;
      r_req    <= 1'b0;
      r_vreset <= 1'b1;
      r_oe     <= 1'b0;
    end else begin
      case (r_state)
        S_DEBOUNCE: begin
          r_primed <= 1'b1;
          r_cand   <= i_config_data;
          if (!w_cand_eq) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_cnt <= '0;
            if (r_init || (i_config_data != r_active)) begin
              r_state <= S_RECONF;
              r_req   <= 1'b1;
              r_mode  <= i_config_data;
            end else begin
              r_state <= S_WAIT_LOCK;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_RECONF: begin
          if (i_pll_reconf_ack) begin
            r_req    <= 1'b0;
            r_active <= r_cand;
            r_init   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          if (w_settled) begin
            r_state  <= S_RUN;
            r_cnt    <= '0;
            r_vreset <= 1'b0;
            r_oe     <= 1'b1;
          end else if (w_timeout) begin
            r_state <= S_RECONF;
            r_cnt   <= '0;
            r_cand  <= r_active;
            r_mode  <= r_active;
            r_req   <= 1'b1;
          end else begin
            r_cnt <= i_pll_locked ? w_cnt_inc : '0;
          end
        end
        S_RUN: begin
          // Lock loss wins over a pending mode change and skips reprogramming.
          if (!i_pll_locked) begin
            r_state  <= S_WAIT_LOCK;
            r_cnt    <= '0;
            r_oe     <= 1'b0;
            r_vreset <= 1'b1;
          end else if (i_config_changed || (i_config_data != r_active)) begin
            r_state <= S_BLANK;
            r_cnt   <= '0;
            r_oe    <= 1'b0;
          end
        end
        S_BLANK: begin
          if (r_cnt == BL_LAST) begin
            r_state  <= S_DEBOUNCE;
            r_cnt    <= '0;
            r_vreset <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state  <= S_DEBOUNCE;
          r_cnt    <= '0;
          r_req    <= 1'b0;
          r_vreset <= 1'b1;
          r_oe     <= 1'b0;
        end
      endcase
    end
  end
  assign o_pll_reconf_req  = r_req;
  assign o_pll_reconf_mode = r_mode;
  assign o_video_reset     = r_vreset;
  assign o_output_enable   = r_oe;
  assign o_active_mode     = r_active;
  assign o_busy            = (r_state != S_RUN);
endmodule

// File: tb/tb_mode_switch_sequencer.sv
// tb_mode_switch_sequencer: directed scenarios for mode_switch_sequencer with small timing parameters.
`ifndef MODE_VGA
`define MODE_VGA 8'h01
`endif
`ifndef MODE_720p
`define MODE_720p 8'h02
`endif
`ifndef MODE_1080p
`define MODE_1080p 8'h03
`endif
module tb_mode_switch_sequencer;
  localparam logic [7:0] VGA = `MODE_VGA;
  localparam logic [7:0] M720 = `MODE_720p;
  localparam logic [7:0] M1080 = `MODE_1080p;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] cfg = M720;
  logic chg = 1'b0;
  logic ack = 1'b0;
  logic locked = 1'b1;
  logic req, vreset, oe, busy, err;
  logic [7:0] rmode, amode;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  mode_switch_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .BLANK_CYCLES(3),
    .SETTLE_CYCLES(5),
    .LOCK_TIMEOUT(20)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_config_data(cfg),
    .i_config_changed(chg),
    .o_pll_reconf_req(req),
    .o_pll_reconf_mode(rmode),
    .i_pll_reconf_ack(ack),
    .i_pll_locked(locked),
    .o_video_reset(vreset),
    .o_output_enable(oe),
    .o_active_mode(amode),
    .o_busy(busy),
    .o_error(err)
  );
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    tick(3);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got=%b want=0", req); end
    checks++; if (vreset !== 1'b1 || oe !== 1'b0) begin errors++; $display("FAIL rst_video: vreset=%b oe=%b want 1 0", vreset, oe); end
    checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rst_flags: busy=%b err=%b want 1 0", busy, err); end
    checks++; if (amode !== VGA || rmode !== VGA) begin errors++; $display("FAIL rst_modes: active=%h reconf=%h want %h", amode, rmode, VGA); end
  endtask
  task automatic test_power_up;
    rst_n = 1'b1;
    tick(3);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL pu_req_early: got=%b want=0", req); end
    tick(1);
    checks++; if (req !== 1'b1 || rmode !== M720) begin errors++; $display("FAIL pu_req: req=%b mode=%h want 1 %h", req, rmode, M720); end
    tick(1);
    checks++; if (req !== 1'b1 || rmode !== M720) begin errors++; $display("FAIL pu_req_hold: req=%b mode=%h want 1 %h", req, rmode, M720); end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checks++; if (req !== 1'b0 || amode !== M720) begin errors++; $display("FAIL pu_ack: req=%b active=%h want 0 %h", req, amode, M720); end
    tick(4);
    checks++; if (oe !== 1'b0 || vreset !== 1'b1) begin errors++; $display("FAIL pu_settle_early: oe=%b vreset=%b want 0 1", oe, vreset); end
    tick(1);
    checks++; if (oe !== 1'b1 || vreset !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL pu_run: oe=%b vreset=%b busy=%b want 1 0 0", oe, vreset, busy); end
  endtask
  task automatic test_mode_change;
    cfg = M1080;
    chg = 1'b1;
    tick(1);
    chg = 1'b0;
    checks++; if (oe !== 1'b0 || vreset !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mc_blank: oe=%b vreset=%b busy=%b want 0 0 1", oe, vreset, busy); end
    tick(2);
    checks++; if (vreset !== 1'b0) begin errors++; $display("FAIL mc_blank_hold: vreset=%b want 0", vreset); end
    tick(1);
    checks++; if (vreset !== 1'b1) begin errors++; $display("FAIL mc_vreset: vreset=%b want 1", vreset); end
    tick(4);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL mc_req_early: got=%b want=0", req); end
    tick(1);
    checks++; if (req !== 1'b1 || rmode !== M1080) begin errors++; $display("FAIL mc_req: req=%b mode=%h want 1 %h", req, rmode, M1080); end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checks++; if (req !== 1'b0 || amode !== M1080) begin errors++; $display("FAIL mc_ack: req=%b active=%h want 0 %h", req, amode, M1080); end
    tick(4);
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL mc_settle_early: oe=%b want 0", oe); end
    tick(1);
    checks++; if (oe !== 1'b1 || vreset !== 1'b0) begin errors++; $display("FAIL mc_run: oe=%b vreset=%b want 1 0", oe, vreset); end
  endtask
  task automatic test_bounce;
    cfg = VGA;
    chg = 1'b1;
    tick(1);
    chg = 1'b0;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      cfg = (i % 2 == 0) ? M720 : VGA;
      tick(2);
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL bn_no_req%0d: got=%b want=0", i, req); end
    end
    tick(2);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL bn_req_early: got=%b want=0", req); end
    tick(1);
    checks++; if (req !== 1'b1 || rmode !== M720) begin errors++; $display("FAIL bn_req: req=%b mode=%h want 1 %h", req, rmode, M720); end
    tick(1);
    checks++; if (req !== 1'b1 || rmode !== M720) begin errors++; $display("FAIL bn_req_hold: req=%b mode=%h want 1 %h", req, rmode, M720); end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL bn_single_req%0d: got=%b want=0", i, req); end
      tick(1);
    end
    checks++; if (oe !== 1'b1 || amode !== M720) begin errors++; $display("FAIL bn_run: oe=%b active=%h want 1 %h", oe, amode, M720); end
  endtask
  task automatic test_glitch_back;
    cfg = VGA;
    tick(1);
    cfg = M720;
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL gl_blank: oe=%b want 0", oe); end
    for (int i = 0; i < 11; i++) begin
      tick(1);
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL gl_no_req%0d: got=%b want=0", i, req); end
    end
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL gl_settle_early: oe=%b want 0", oe); end
    tick(1);
    checks++; if (oe !== 1'b1 || amode !== M720 || busy !== 1'b0) begin errors++; $display("FAIL gl_run: oe=%b active=%h busy=%b want 1 %h 0", oe, amode, busy, M720); end
  endtask
  task automatic test_lock_loss;
    locked = 1'b0;
    tick(1);
    checks++; if (oe !== 1'b0 || vreset !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ll_drop: oe=%b vreset=%b busy=%b want 0 1 1", oe, vreset, busy); end
    tick(1);
    locked = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++; if (req !== 1'b0 || oe !== 1'b0) begin errors++; $display("FAIL ll_wait%0d: req=%b oe=%b want 0 0", i, req, oe); end
    end
    tick(1);
    checks++; if (oe !== 1'b1 || vreset !== 1'b0 || amode !== M720) begin errors++; $display("FAIL ll_run: oe=%b vreset=%b active=%h want 1 0 %h", oe, vreset, amode, M720); end
  endtask
  task automatic test_ack_early;
    ack = 1'b1;
    cfg = M1080;
    chg = 1'b1;
    tick(1);
    chg = 1'b0;
    checks++; if (oe !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL ae_blank: oe=%b req=%b want 0 0", oe, req); end
    tick(7);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL ae_req_early: got=%b want=0", req); end
    tick(1);
    checks++; if (req !== 1'b1 || rmode !== M1080) begin errors++; $display("FAIL ae_req: req=%b mode=%h want 1 %h", req, rmode, M1080); end
    tick(1);
    ack = 1'b0;
    checks++; if (req !== 1'b0 || amode !== M1080) begin errors++; $display("FAIL ae_one_cycle: req=%b active=%h want 0 %h", req, amode, M1080); end
    tick(5);
    checks++; if (oe !== 1'b1 || vreset !== 1'b0) begin errors++; $display("FAIL ae_run: oe=%b vreset=%b want 1 0", oe, vreset); end
  endtask
  task automatic test_timeout;
    locked = 1'b0;
    tick(20);
    checks++; if (err !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL to_early: err=%b req=%b want 0 0", err, req); end
    tick(1);
`ifdef MODE_SWITCH_LOCK_TIMEOUT_EN
    checks++; if (err !== 1'b1 || req !== 1'b1 || rmode !== M1080) begin errors++; $display("FAIL to_fire: err=%b req=%b mode=%h want 1 1 %h", err, req, rmode, M1080); end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checks++; if (req !== 1'b0 || err !== 1'b1 || amode !== M1080) begin errors++; $display("FAIL to_ack: req=%b err=%b active=%h want 0 1 %h", req, err, amode, M1080); end
`else
    checks++; if (err !== 1'b0 || req !== 1'b0 || oe !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_none: err=%b req=%b oe=%b busy=%b want 0 0 0 1", err, req, oe, busy); end
    tick(20);
    checks++; if (err !== 1'b0 || req !== 1'b0 || oe !== 1'b0) begin errors++; $display("FAIL to_wait: err=%b req=%b oe=%b want 0 0 0", err, req, oe); end
`endif
    locked = 1'b1;
    tick(4);
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL to_settle_early: oe=%b want 0", oe); end
    tick(1);
    checks++; if (oe !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_run: oe=%b busy=%b want 1 0", oe, busy); end
`ifdef MODE_SWITCH_LOCK_TIMEOUT_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky: err=%b want 1", err); end
`endif
  endtask
  task automatic test_async_reset;
    cfg = M720;
    chg = 1'b1;
    tick(1);
    chg = 1'b0;
    tick(8);
    checks++; if (req !== 1'b1 || rmode !== M720) begin errors++; $display("FAIL ar_req: req=%b mode=%h want 1 %h", req, rmode, M720); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0 || vreset !== 1'b1 || oe !== 1'b0) begin errors++; $display("FAIL ar_drop: req=%b vreset=%b oe=%b want 0 1 0", req, vreset, oe); end
    checks++; if (amode !== VGA || err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ar_state: active=%h err=%b busy=%b want %h 0 1", amode, err, busy, VGA); end
    tick(2);
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset;
    test_power_up;
    test_mode_change;
    test_bounce;
    test_glitch_back;
    test_lock_loss;
    test_ack_early;
    test_timeout;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
